uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among N_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes and drives the transmitter's trmt/tx_data pair. Waits for its tx_done pulse before issuing the next byte.
- Also generates the shared baud_en strobe from a programmable divisor.
- Supports packet locking: a requester keeps the grant until it sends a byte flagged last.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- DIV_W, 16, width of baud divisor/counter.
- LOCK_TIMEOUT, 1024, idle cycles before a stalled lock is broken (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- baud_div  in  DIV_W  baud_en period minus 1.
- req_valid  in  N_REQ  byte available, per requester.
- req_data  in  8*N_REQ  byte for requester i at bits [8i+7:8i].
- req_last  in  N_REQ  byte ends a packet; releases the lock.
- req_ready  out  N_REQ  one-hot accept strobe.
- trmt  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to transmit; stable from trmt until the next accept.
- tx_done  in  1  one-cycle pulse from the transmitter at end of frame.
- baud_en  out  1  one-cycle baud strobe to the transmitter.
- grant_id  out  max(1,$clog2(N_REQ))  current/last granted requester.
- locked  out  1  a packet lock is held.
- busy  out  1  state != ARB.
- lock_err  out  1  sticky; lock broken by timeout (optional feature only, else tied 0).

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All flops reset asynchronously. Reset values:
  - State ARB; rr_ptr=0; baud counter=0.
  - All outputs 0: req_ready, trmt, tx_data, baud_en, grant_id, locked, busy, lock_err.
- Reset mid-frame abandons the byte and clears the lock. No replay.
- Baud generator:
  - Registered. Each cycle, if cnt>=baud_div then cnt<=0 and baud_en<=1; otherwise cnt<=cnt+1 and baud_en<=0.
  - Period is baud_div+1 cycles; baud_div=0 gives baud_en every cycle.
  - Lowering baud_div mid-count takes effect on the next compare. No wrap glitch.
- States: ARB, SEND, WAIT_DONE.
- ARB:
  - If locked: only grant_id is eligible.
  - Else: pick the first i with req_valid[i], searching from rr_ptr upward modulo N_REQ.
  - req_ready is combinational, asserted only for the chosen i and only in ARB. Accept = valid & ready.
  - On accept:
    - tx_data<=req_data[i] and grant_id<=i.
    - locked<=!req_last[i].
    - If req_last[i]: rr_ptr<=(i+1) mod N_REQ.
    - Go to SEND.
  - No valid input: stay in ARB.
- SEND: trmt=1 for exactly this cycle; go to WAIT_DONE.
- WAIT_DONE:
  - Hold until tx_done=1, then go to ARB.
  - req_ready is low throughout.
  - A tx_done seen in SEND or ARB is ignored.
- Latency: accept at cycle A, trmt at A+1. The next accept is possible at the cycle after tx_done is sampled.
- Simultaneous valid inputs: round-robin order, so none starves. A locked owner blocks all others until its last byte.
- Locked owner deasserts valid: the scheduler waits in ARB indefinitely (without the feature).
- req_valid may drop without accept. The scheduler does not require valid to be held.
- N_REQ=1: grant_id is constantly 0 and rr_ptr is unused.

Optional Feature:
- Macro: UART_SCHED_LOCK_TIMEOUT_EN.
- Defined:
  - A counter runs while in ARB with locked=1 and req_valid[grant_id]=0. It clears on accept.
  - When it reaches LOCK_TIMEOUT: locked<=0, lock_err<=1 (sticky until reset), rr_ptr<=(grant_id+1) mod N_REQ.
- Undefined: no counter; lock_err is tied 0; the lock is held forever.

Decomposition:
- Package uart_pkg:
  - sched_state_t enum {ARB, SEND, WAIT_DONE}.
  - Constants: BYTE_W=8, default DIV_W.
- Sub-module uart_baud_gen (clk, rst_n, baud_div, baud_en), reusable by the receive side.
- Arbitration and FSM stay in uart_tx_sched.

Test Plan:
- Basic byte: baud_div=3, only req0 valid with 0xA5, last=1.
  - Expect ready[0] for 1 cycle and trmt the next cycle with tx_data=0xA5.
  - With a UART_tx model attached: frame TX pattern 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit. Then tx_done, then back in ARB.
- Round robin: all 4 requesters valid, last=1, data 0x10..0x13.
  - Expect grant order 0,1,2,3,0.
  - Expect no ready during SEND/WAIT_DONE.
- Packet lock: req1 sends 3 bytes (last on the 3rd) while req2 is valid.
  - Expect 3 consecutive req1 grants with locked=1, then req2.
- Baud divisor: baud_div=0 gives baud_en every cycle.
  - Switching to 9 mid-count gives a 10-cycle period, with no pulse missed or doubled beyond one period.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE.
  - Expect trmt=0, locked=0, grant_id=0, busy=0 immediately.
  - After release: normal accept from req0.
- Timeout (macro on, LOCK_TIMEOUT=16): req3 sends a non-last byte, then drops valid while req0 is valid.
  - After 16 idle cycles: lock_err=1, locked=0, next grant is req0.
  - With the macro off, req0 is never granted.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the UART scheduling blocks
package uart_pkg;
  typedef enum logic [1:0] {ARB, SEND, WAIT_DONE} sched_state_t;
  localparam int BYTE_W = 8;
  localparam int DEF_DIV_W = 16;
  function automatic int wrap_add(int a, int b, int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable baud strobe, one pulse every baud_div+1 cycles
//   clk, rst_n : clock, async active-low reset
//   baud_div   : strobe period minus 1
//   baud_en    : registered one-cycle strobe
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  output logic             baud_en
);
  logic [DIV_W-1:0] cnt;
  // >= rather than == so a divisor lowered below the running count fires at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      baud_en <= 1'b0;
    end else begin
      cnt <= (cnt >= baud_div) ? '0 : cnt + 1'b1;
      baud_en <= (cnt >= baud_div);
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among N_REQ producers
//   clk, rst_n          : clock, async active-low reset
//   baud_div / baud_en  : baud divisor in, shared baud strobe out
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   trmt/tx_data/tx_done: transmitter start pulse, byte, end-of-frame pulse
//   grant_id/locked/busy/lock_err : status
//   UART_SCHED_LOCK_TIMEOUT_EN: break a stalled packet lock after LOCK_TIMEOUT idle cycles
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIV_W = DEF_DIV_W,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int GW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_W-1:0]      baud_div,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  trmt,
  output logic [BYTE_W-1:0]     tx_data,
  input  logic                  tx_done,
  output logic                  baud_en,
  output logic [GW-1:0]         grant_id,
  output logic                  locked,
  output logic                  busy,
  output logic                  lock_err
);
  sched_state_t state;
  logic [GW-1:0] rr_ptr, sel, cand;
  logic found, to_hit;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .baud_en(baud_en)
  );

  // Scan downward so the requester nearest rr_ptr is the last (winning) write
  always_comb begin
    sel = grant_id;
    cand = '0;
    found = locked && req_valid[grant_id];
    if (!locked)
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = GW'(wrap_add(int'(rr_ptr), k, N_REQ));
        if (req_valid[cand]) begin
          sel = cand;
          found = 1'b1;
        end
      end
  end

  assign req_ready = (state == ARB && found) ? N_REQ'(1) << sel : '0;

`ifdef UART_SCHED_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  assign to_hit = state == ARB && locked && !found && to_cnt == TW'(LOCK_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      to_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      to_cnt <= (state != ARB || found || !locked || to_hit) ? (found || to_hit ? '0 : to_cnt) : to_cnt + 1'b1;
      lock_err <= lock_err | to_hit;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^LOCK_TIMEOUT;
  assign to_hit = 1'b0;
  assign lock_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB;
      rr_ptr <= '0;
      grant_id <= '0;
      tx_data <= '0;
      locked <= 1'b0;
      trmt <= 1'b0;
      busy <= 1'b0;
    end else begin
      trmt <= 1'b0;
      case (state)
        ARB:
          if (found) begin
            tx_data <= req_data[int'(sel)*BYTE_W +: BYTE_W];
            grant_id <= sel;
            locked <= !req_last[sel];
            if (req_last[sel]) rr_ptr <= GW'(wrap_add(int'(sel), 1, N_REQ));
            trmt <= 1'b1;
            busy <= 1'b1;
            state <= SEND;
          end else if (to_hit) begin
            locked <= 1'b0;
            rr_ptr <= GW'(wrap_add(int'(grant_id), 1, N_REQ));
          end
        SEND: state <= WAIT_DONE;
        WAIT_DONE:
          if (tx_done) begin
            busy <= 1'b0;
            state <= ARB;
          end
        default: state <= ARB;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
  logic clk = 1'b0, rst_n = 1'b0, tx_done = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [31:0] req_data = '0;
  logic trmt, baud_en, locked, busy, lock_err;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int checks = 0, errors = 0, n, hits;

  uart_tx_sched #(.N_REQ(4), .DIV_W(16), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .req_valid(req_valid),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready), .trmt(trmt),
    .tx_data(tx_data), .tx_done(tx_done), .baud_en(baud_en), .grant_id(grant_id),
    .locked(locked), .busy(busy), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic frame_done;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic do_reset;
    req_valid = '0;
    req_last = '0;
    tx_done = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask

  task automatic baud_gap(output int g);
    g = 0;
    do begin
      step();
      g++;
    end while (!baud_en && g < 40);
  endtask

  initial begin
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_baud_en", baud_en, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lock_err", lock_err, 0);
    rst_n = 1'b1;
    step();
    baud_gap(n);
    baud_gap(n);
    chk("baud_div3_period", n, 4);

    req_valid = 4'b0001; req_data = 32'h0000_00A5; req_last = 4'b0001;
    #1;
    chk("basic_ready", req_ready, 4'b0001);
    chk("basic_idle", busy, 0);
    step();
    chk("basic_trmt", trmt, 1);
    chk("basic_data", tx_data, 8'hA5);
    chk("basic_ready_send", req_ready, 0);
    req_valid = '0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("basic_trmt_once", trmt, 0);
    step(3);
    chk("send_done_ignored", busy, 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("basic_back_arb", busy, 0);

    do_reset();
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_ready%0d", i), req_ready, 32'd1 << (i % 4));
      step();
      chk($sformatf("rr_grant%0d", i), grant_id, i % 4);
      chk($sformatf("rr_data%0d", i), tx_data, 8'h10 + i % 4);
      chk($sformatf("rr_noready_send%0d", i), req_ready, 0);
      step();
      chk($sformatf("rr_noready_wait%0d", i), req_ready, 0);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end

    do_reset();
    req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h0000_2100;
    #1;
    chk("lock_ready1", req_ready, 4'b0010);
    step();
    chk("lock_locked1", locked, 1);
    chk("lock_grant1", grant_id, 1);
    req_valid = 4'b0111; req_data = 32'h0030_2240;
    frame_done();
    #1;
    chk("lock_ready2", req_ready, 4'b0010);
    step();
    chk("lock_data2", tx_data, 8'h22);
    chk("lock_locked2", locked, 1);
    req_data = 32'h0030_2340; req_last = 4'b0010;
    frame_done();
    #1;
    chk("lock_ready3", req_ready, 4'b0010);
    step();
    chk("lock_data3", tx_data, 8'h23);
    chk("lock_released", locked, 0);
    req_valid = 4'b0101; req_last = 4'b0101;
    frame_done();
    #1;
    chk("lock_next_ready", req_ready, 4'b0100);
    step();
    chk("lock_next_grant", grant_id, 2);
    chk("lock_next_data", tx_data, 8'h30);
    req_valid = '0;
    frame_done();

    baud_div = 16'd0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("baud_div0_%0d", i), baud_en, 1);
      step();
    end
    baud_div = 16'd9;
    baud_gap(n);
    chk("baud_div9_first", n, 10);
    baud_gap(n);
    chk("baud_div9_period", n, 10);
    step(5);
    baud_div = 16'd2;
    step();
    chk("baud_lower_midcount", baud_en, 1);
    baud_gap(n);
    chk("baud_div2_period", n, 3);

    baud_div = 16'd3;
    req_valid = 4'b0100; req_last = '0; req_data = 32'h0055_0000;
    step(2);
    chk("mid_busy", busy, 1);
    chk("mid_locked", locked, 1);
    chk("mid_grant", grant_id, 2);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trmt", trmt, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    step(2);
    rst_n = 1'b1;
    step();
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_0066;
    #1;
    chk("post_rst_ready", req_ready, 4'b0001);
    step();
    chk("post_rst_trmt", trmt, 1);
    chk("post_rst_data", tx_data, 8'h66);
    frame_done();

    req_valid = 4'b1000; req_last = '0; req_data = 32'h7700_0011;
    #1;
    chk("to_ready3", req_ready, 4'b1000);
    step();
    chk("to_locked", locked, 1);
    chk("to_grant", grant_id, 3);
    req_valid = 4'b0001; req_last = 4'b0001;
    frame_done();
`ifdef UART_SCHED_LOCK_TIMEOUT_EN
    n = 0;
    while (locked && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_lock_err", lock_err, 1);
    chk("to_unlocked", locked, 0);
    #1;
    chk("to_next_ready", req_ready, 4'b0001);
`else
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready != 0) hits++;
      step();
    end
    chk("nolock_to_starve", hits, 0);
    chk("nolock_to_locked", locked, 1);
    chk("nolock_to_err", lock_err, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
